// File: rtl/bit_serializer_pkg.sv
// Shared serial-stream definitions for the bit-stream front end.
// State encoding and serial idle level used by bit_serializer.
package bit_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam logic SER_IDLE = 1'b0;

endpackage

// File: rtl/bit_serializer.sv
// MSB-first parallel-to-serial front end for the sequence detectors.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit per word.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nx;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nx;
    logic             x_nx;
    logic             last;
    logic             xfer;

    assign last = (cnt == '0);
    assign xfer = din_valid && din_ready;

`ifdef BIT_SERIALIZER_PARITY_EN
    logic par;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par <= 1'b0;
        end else if (xfer) begin
            par <= ^din;
        end
    end
`endif

    // Ready depends on state alone so upstream never sees a loop
    always_comb begin
        din_ready = 1'b0;
        unique case (state)
            IDLE:    din_ready = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
            SHIFT:   din_ready = 1'b0;
            PARITY:  din_ready = 1'b1;
`else
            SHIFT:   din_ready = last;
`endif
            default: din_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        cnt_nx   = cnt;
        x_nx     = SER_IDLE;
        unique case (state)
            IDLE: begin
                x_nx = SER_IDLE;
            end
            SHIFT: begin
                x_nx     = shreg[WIDTH-1];
                shreg_nx = {shreg[WIDTH-2:0], 1'b0};
                if (!last) begin
                    cnt_nx = cnt - 1'b1;
                end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
                    state_nx = PARITY;
`else
                    state_nx = IDLE;
`endif
                end
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            PARITY: begin
                x_nx     = par;
                state_nx = IDLE;
            end
`endif
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (xfer) begin
            shreg_nx = din;
            cnt_nx   = CNT_LAST;
            state_nx = SHIFT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            x       <= SER_IDLE;
            x_valid <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nx;
            shreg   <= shreg_nx;
            cnt     <= cnt_nx;
            x       <= x_nx;
            x_valid <= (state != IDLE);
            busy    <= (state != IDLE);
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer (WIDTH=4 and WIDTH=8 instances).
// Reference is a queue of pending serial bits filled per accepted word.
module tb_bit_serializer;

`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] din4 = '0;
    logic       v4 = 1'b0;
    logic       rdy4, x4, xv4, b4;
    logic [7:0] din8 = '0;
    logic       v8 = 1'b0;
    logic       rdy8, x8, xv8, b8;

    int tests = 0;
    int fails = 0;
    bit q[$];
    logic [15:0] rec = '0;

    logic       e2e = 1'b0;
    logic [3:0] win;
    int         pulses;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .din(din4), .din_valid(v4),
        .din_ready(rdy4), .x(x4), .x_valid(xv4), .busy(b4)
    );

    bit_serializer #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .din(din8), .din_valid(v8),
        .din_ready(rdy8), .x(x8), .x_valid(xv8), .busy(b8)
    );

    // Overlapping 1010 detector watching the serial line every clock
    always @(negedge clk) begin
        if (!e2e) begin
            win    <= '0;
            pulses <= 0;
        end else begin
            win <= {win[2:0], x8};
            if ({win[2:0], x8} == 4'b1010) pulses <= pulses + 1;
        end
    end

    typedef struct {
        logic [3:0] din;
        logic [3:0] bits;
        logic       par;
    } vec_t;

    vec_t tv[5];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(output bit xf);
        logic [3:0] w;
        bit ex;
        bit ev;
        chk("din_ready", {31'd0, rdy4}, {31'd0, q.size() <= 1});
        xf = v4 && (q.size() <= 1);
        w = din4;
        @(posedge clk);
        #1;
        ex = 1'b0;
        ev = 1'b0;
        if (q.size() > 0) begin
            ex = q.pop_front();
            ev = 1'b1;
        end
        if (xf) begin
            for (int i = 3; i >= 0; i--) q.push_back(w[i]);
            if (PB == 1) q.push_back(^w);
        end
        rec = {rec[14:0], x4};
        chk("x", {31'd0, x4}, {31'd0, ex});
        chk("x_valid", {31'd0, xv4}, {31'd0, ev});
        chk("busy", {31'd0, b4}, {31'd0, ev});
    endtask

    task automatic steps(input int n);
        bit xf;
        for (int i = 0; i < n; i++) step(xf);
    endtask

    task automatic hold_word(input logic [3:0] d);
        bit xf;
        xf = 1'b0;
        din4 = d;
        v4 = 1'b1;
        for (int k = 0; k < 20 && !xf; k++) step(xf);
        if (!xf) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic feed8(input logic [7:0] d);
        bit acc;
        acc = 1'b0;
        din8 = d;
        v8 = 1'b1;
        for (int k = 0; k < 30 && !acc; k++) begin
            acc = rdy8;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("accept8_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bit xf;
        tv[0] = '{4'b1010, 4'b1010, 1'b0};
        tv[1] = '{4'b1101, 4'b1101, 1'b1};
        tv[2] = '{4'b0001, 4'b0001, 1'b1};
        tv[3] = '{4'b1111, 4'b1111, 1'b0};
        tv[4] = '{4'b0000, 4'b0000, 1'b0};

        @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, rdy4}, 32'd1);
        chk("rst_x", {31'd0, x4}, 32'd0);
        chk("rst_xvalid", {31'd0, xv4}, 32'd0);
        chk("rst_busy", {31'd0, b4}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tv[n]) begin
            hold_word(tv[n].din);
            v4 = 1'b0;
            for (int i = 0; i < 4; i++) begin
                step(xf);
                chk("tbl_bit", {31'd0, x4}, {31'd0, tv[n].bits[3-i]});
                chk("tbl_valid", {31'd0, xv4}, 32'd1);
            end
            if (PB == 1) begin
                step(xf);
                chk("tbl_par", {31'd0, x4}, {31'd0, tv[n].par});
            end
            step(xf);
            chk("tbl_idle", {29'd0, x4, xv4, b4}, 32'd0);
        end

        rec = '0;
        hold_word(4'b1101);
        hold_word(4'b0110);
        v4 = 1'b0;
        steps(4 + PB);
        if (PB == 1) chk("b2b_stream", {22'd0, rec[9:0]}, 32'b11011_01100);
        else         chk("b2b_stream", {24'd0, rec[7:0]}, 32'b1101_0110);
        steps(2);

        rec = '0;
        hold_word(4'b1111);
        din4 = 4'b0000;
        hold_word(4'b0000);
        v4 = 1'b0;
        if (PB == 1) chk("din_change", {28'd0, rec[4:1]}, 32'hF);
        else         chk("din_change", {28'd0, rec[3:0]}, 32'hF);
        steps(4 + PB + 2);

        hold_word(4'b1001);
        v4 = 1'b0;
        steps(2);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_x", {31'd0, x4}, 32'd0);
        chk("midrst_xvalid", {31'd0, xv4}, 32'd0);
        chk("midrst_busy", {31'd0, b4}, 32'd0);
        chk("midrst_ready", {31'd0, rdy4}, 32'd1);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        steps(6);

        for (int c = 0; c < 400; c++) begin
            if (!v4 && $urandom_range(0, 2) == 0) begin
                v4 = 1'b1;
                din4 = 4'($urandom);
            end
            step(xf);
            if (xf) begin
                if ($urandom_range(0, 1) == 1) din4 = 4'($urandom);
                else v4 = 1'b0;
            end
        end
        v4 = 1'b0;
        steps(8);
        chk("rand_drain", {31'd0, b4}, 32'd0);

        e2e = 1'b1;
        @(posedge clk);
        #1;
        feed8(8'b1010_1010);
        feed8(8'b0000_0000);
        v8 = 1'b0;
        for (int k = 0; k < 24; k++) @(posedge clk);
        #1;
        chk("e2e_pulses", pulses, 32'd3);
        chk("e2e_idle", {29'd0, x8, xv8, b8}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the bit-stream sequence detectors. Accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per clock, on a registered serial output. The serial output drives the detector's serial input `x`. Back-to-back words stream with no idle gap between them.

## Interface
- WIDTH, 8, word width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous and active-high.
- din  input  WIDTH  parallel word.
- din_valid  input  1  din holds a word.
- din_ready  output  1  the block accepts din this cycle. Combinational from state only, never from din_valid.
- x  output  1  serial bit, registered; feeds the detector's `x`.
- x_valid  output  1  x carries a real data or parity bit this cycle, registered.
- busy  output  1  a word is in flight (state != IDLE), registered.

## Operation
- Transfer: occurs on a rising clk edge when din_valid && din_ready. din is captured into the shift register shreg and the bit counter is loaded with WIDTH-1.
- State machine:
  - IDLE:
    - din_ready=1.
    - On transfer: go to SHIFT.
    - x=0, x_valid=0.
  - SHIFT:
    - Each cycle, x <= shreg[WIDTH-1], shreg shifts left by one with 0 fill, and cnt decrements.
    - On the cycle presenting the last bit (cnt==0):
      - Parity build: go to PARITY; din_ready=0.
      - Otherwise: din_ready=1. A transfer reloads shreg and the block stays in SHIFT. With no transfer, the block returns to IDLE.
  - PARITY (parity build only):
    - Presents one even-parity bit, the XOR of the word's bits.
    - din_ready=1. A transfer goes to SHIFT; otherwise the block goes to IDLE.
- A din_valid asserted while din_ready=0 is ignored, not queued. The upstream must hold din and din_valid until the transfer.
- din is sampled only on the transfer edge. Later changes to din do not affect the word in flight.
- cnt width is $clog2(WIDTH). cnt never wraps: it is reloaded before it would underflow.
- The block has no downstream back-pressure. The detector consumes one bit per clock unconditionally.
- Reset mid-word: the word is discarded, no partial bits follow, and the state returns to IDLE.

## Timing
- Reset values: x=0, x_valid=0, busy=0, state=IDLE, shreg=0, cnt=0. din_ready=1 while rst is high.
- Latency: a word transferred at edge N drives its MSB on x after edge N+1, and its LSB after edge N+WIDTH.
- Throughput:
  - Base build: one word per WIDTH cycles, with x_valid continuously high for back-to-back words.
  - Parity build: one word per WIDTH+1 cycles.
- busy rises with the first bit. It falls one cycle after the last bit (data or parity) if there is no follow-on transfer.
- Simultaneous last-bit output and new transfer: the next word's MSB follows the current LSB (or parity bit) on the very next cycle, with no gap.

## Configuration
- Macro: BIT_SERIALIZER_PARITY_EN.
- Defined:
  - The PARITY state exists.
  - After each word's LSB, one even-parity bit is emitted with x_valid=1.
  - din_ready is low on the LSB cycle and high during the PARITY cycle.
- Undefined:
  - No PARITY state.
  - The next word's MSB directly follows the LSB.
  - din_ready is high on the LSB cycle.

## Structure
- The shared serial-stream package holds:
  - the state typedef (IDLE, SHIFT, PARITY), 2-bit encoding;
  - the serial idle-level constant (0).
- Single module. No sub-module is warranted: the shift register, counter and parity XOR-reduce are all trivial inline.

## Test plan
- WIDTH=4, reset released, din=4'b1010 pulsed valid for one cycle:
  - Base build: x = 1,0,1,0 with x_valid=1 on the four cycles after the transfer, then x=0, x_valid=0, busy=0.
  - Parity build: a fifth bit x=0 follows.
- Back-to-back 4'b1101 then 4'b0110, din_valid held high: base build gives x = 1,1,0,1,0,1,1,0 with no x_valid gap. din_ready=1 only in IDLE and on the LSB cycles.
- din_valid high with din changing mid-word (4'b1111 accepted, then din=4'b0000 while busy): the output remains 1,1,1,1, and the second word is accepted only when din_ready=1.
- rst asserted asynchronously on the second bit of 4'b1001: x, x_valid and busy drop to 0 immediately, and no further bits of that word appear after release.
- End-to-end: the serializer drives the detector, streaming WIDTH=8 words 8'b1010_1010 then 8'b0000_0000. The detector output pulses on the overlapping 1010 occurrences (every second bit from the 4th), with no spurious pulse from idle zeros.
